// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock qualification and system reset release
// Synchronises PLL lock, retries on lock timeout, and holds the SoC in reset until lock is stable.
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 48000,
  parameter int SYNC_STAGES         = 2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_locked,
  output logic       pll_reset,
  output logic       sys_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_P  = (MAX_A > LOCK_TIMEOUT_CYCLES) ? MAX_A : LOCK_TIMEOUT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] C_RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_WAIT_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_PLL_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_pll_reset;
  logic                   r_sys_reset;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic [3:0]             r_retry_count;

  logic       w_locked_sync;
  logic [1:0] w_next_state;
  logic       w_timeout;

  assign w_locked_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_next_state = r_state;
    w_timeout    = 1'b0;
    case (r_state)
      S_PLL_RST: begin
        if (r_cnt == C_RST_LAST) w_next_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // A lock seen on the timeout edge still counts as a lock
        if (w_locked_sync) begin
          w_next_state = S_STABLE;
        end else if (r_cnt == C_WAIT_LAST) begin
          w_next_state = S_PLL_RST;
          w_timeout    = 1'b1;
        end
      end
      S_STABLE: begin
        if (!w_locked_sync)                w_next_state = S_WAIT_LOCK;
        else if (r_cnt == C_STABLE_LAST)   w_next_state = S_RUN;
      end
      default: begin
        if (!w_locked_sync) w_next_state = S_PLL_RST;
      end
    endcase
  end

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      r_state       <= S_PLL_RST;
      r_cnt         <= '0;
      r_sync        <= '0;
      r_pll_reset   <= 1'b1;
      r_sys_reset   <= 1'b1;
      r_ready       <= 1'b0;
      r_lock_lost   <= 1'b0;
      r_retry_count <= 4'd0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], pll_locked};
      r_state <= w_next_state;
      if (w_next_state != r_state) r_cnt <= '0;
      else if (r_state != S_RUN)   r_cnt <= r_cnt + 1'b1;
      // Outputs follow the state being entered so they change on the transition edge
      r_pll_reset <= (w_next_state == S_PLL_RST);
      r_sys_reset <= (w_next_state != S_RUN);
      r_ready     <= (w_next_state == S_RUN);
      r_lock_lost <= (r_state == S_RUN) && !w_locked_sync;
      if (w_timeout && r_retry_count != 4'd15) r_retry_count <= r_retry_count + 4'd1;
    end
  end

  assign pll_reset   = r_pll_reset;
  assign sys_reset   = r_sys_reset;
  assign ready       = r_ready;
  assign lock_lost   = r_lock_lost;
  assign retry_count = r_retry_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - scoreboard bench for pll_reset_sequencer
// Randomised lock patterns checked every cycle against a phase-level reference model.
module tb_pll_reset_sequencer;

  localparam int P_RST  = 4;
  localparam int P_STAB = 8;
  localparam int P_TOUT = 32;
  localparam int P_SYNC = 2;

  logic       clk;
  logic       rst;
  logic       lk;
  logic       pll_reset;
  logic       sys_reset;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb[$];

  pll_reset_sequencer #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_STABLE_CYCLES(P_STAB),
    .LOCK_TIMEOUT_CYCLES(P_TOUT),
    .SYNC_STAGES(P_SYNC)
  ) dut (
    .clkin(clk),
    .reset(rst),
    .pll_locked(lk),
    .pll_reset(pll_reset),
    .sys_reset(sys_reset),
    .ready(ready),
    .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: which phase of the bring-up we are in and how long we have been there
  typedef enum int {PH_PULSE, PH_SEEK, PH_CONFIRM, PH_LIVE} phase_t;
  phase_t m_phase;
  int     m_elapsed;
  int     m_retries;
  bit     m_lost;
  bit     m_hist[$];

  task automatic model_step(input logic r, input logic l);
    bit seen;
    if (r) begin
      m_phase = PH_PULSE; m_elapsed = 0; m_retries = 0; m_lost = 0;
      m_hist.delete();
      for (int i = 0; i < P_SYNC; i++) m_hist.push_back(1'b0);
    end else begin
      seen = m_hist.pop_front();
      m_hist.push_back(l);
      m_lost = 0;
      case (m_phase)
        PH_PULSE: begin
          m_elapsed++;
          if (m_elapsed == P_RST) begin m_phase = PH_SEEK; m_elapsed = 0; end
        end
        PH_SEEK: begin
          if (seen) begin
            m_phase = PH_CONFIRM; m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == P_TOUT) begin
              m_phase = PH_PULSE; m_elapsed = 0;
              m_retries = (m_retries < 15) ? m_retries + 1 : 15;
            end
          end
        end
        PH_CONFIRM: begin
          if (!seen) begin
            m_phase = PH_SEEK; m_elapsed = 0;
          end else begin
            m_elapsed++;
            if (m_elapsed == P_STAB) begin m_phase = PH_LIVE; m_elapsed = 0; end
          end
        end
        default: begin
          if (!seen) begin m_phase = PH_PULSE; m_elapsed = 0; m_lost = 1; end
        end
      endcase
    end
  endtask

  function automatic logic [7:0] model_out();
    return {m_phase == PH_PULSE, m_phase != PH_LIVE, m_phase == PH_LIVE, m_lost, 4'(m_retries)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step(rst, lk);
    sb.push_back(model_out());
  endtask

  always @(negedge clk) begin
    logic [7:0] exp_v;
    logic [7:0] got_v;
    if (sb.size() > 0) begin
      exp_v = sb.pop_front();
      got_v = {pll_reset, sys_reset, ready, lock_lost, retry_count};
      checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t got {pll_rst,sys_rst,ready,lost,retry}=%b required=%b",
                 $time, got_v, exp_v);
      end
    end
  end

  task automatic async_reset(input int hold);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({pll_reset, sys_reset, ready, lock_lost, retry_count} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL async_reset t=%0t got=%b required=%b", $time,
               {pll_reset, sys_reset, ready, lock_lost, retry_count}, 8'b1100_0000);
    end
    for (int i = 0; i < hold; i++) tick();
    rst = 1'b0;
  endtask

  task automatic drive_level(input logic v, input int n);
    for (int i = 0; i < n; i++) begin lk = v; tick(); end
  endtask

  initial begin
    int mode;
    int n;
    rst = 1'b1;
    lk  = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;

    // Lock never arrives: retries climb and saturate at 15
    drive_level(1'b0, 700);
    async_reset(3);
    drive_level(1'b0, 2);
    async_reset(2);

    // Clean lock after the pulse ends, then a loss of lock while running
    drive_level(1'b0, P_RST);
    drive_level(1'b1, 40);
    drive_level(1'b0, 1);
    drive_level(1'b1, 40);
    async_reset(2);

    for (int seg = 0; seg < 60; seg++) begin
      mode = $urandom_range(0, 5);
      case (mode)
        0: drive_level(1'b1, $urandom_range(15, 60));
        1: drive_level(1'b0, $urandom_range(1, 45));
        2: for (int i = 0; i < 30; i++) begin lk = ($urandom_range(0, 9) != 0); tick(); end
        3: begin
          n = $urandom_range(1, 12);
          drive_level(1'b1, n);
          drive_level(1'b0, 1);
          drive_level(1'b1, 30);
        end
        4: async_reset($urandom_range(1, 4));
        default: begin
          drive_level(1'b1, 30);
          drive_level(1'b0, $urandom_range(1, 3));
        end
      endcase
    end

    @(negedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d entries required=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
